// File: rtl/sensor_demux_buf_pkg.sv
// Shared constants and helpers for the sensor demultiplexer.
// Contents:
//   DEF_DATA_W / DEF_N_CH : default data width and channel count
//   demux_mode_e          : target selection mode (direct address / scan pointer)
//   clog2()               : constant ceil-log2, used to validate ADDR_W against N_CH
package sensor_demux_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_CH   = 8;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } demux_mode_e;

    // Smallest r such that 2**r >= n (n >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< r) < n) begin
                r = r + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sensor_demux_buf_chan_slot.sv
// demux_chan_slot: one-deep output buffer for a single demux channel.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : write i_data into the slot this cycle (only asserted when o_free)
//   i_data    : word to store
//   i_ready   : consumer ready for this channel
//   o_valid   : slot holds a word
//   o_data    : stored word (zeroed while empty when HOLD_DATA = 0)
//   o_free    : slot can take a load this cycle (empty, or being consumed now)
module demux_chan_slot #(
    parameter int DATA_W    = 8,
    parameter int HOLD_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_free
);
    import sensor_demux_buf_pkg::*;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Free when empty or when the held word leaves this very cycle.
    always_comb begin
        o_free = (~r_valid) | i_ready;
    end

    // Slot storage: a load wins over a consume, so consume+load has no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            if (HOLD_DATA == 0) begin
                r_data <= {DATA_W{1'b0}};
            end else begin
                r_data <= r_data;
            end
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/sensor_demux_buf.sv
// sensor_demux_buf: registered 1-to-N_CH demultiplexer with per-channel
// one-deep buffers and valid/ready handshakes.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input beat valid;  in_ready: beat accepted when both high
//   data_in    : input word
//   address    : target channel in direct mode
//   scan_en    : 1 = round-robin scan pointer selects the target, 0 = address
//   out_valid  : per-channel buffer valid; out_ready: per-channel consumer ready
//   out_data   : channel k at [k*DATA_W +: DATA_W]
//   cur_ch     : current target channel
//   err_addr   : one-cycle pulse after an out-of-range beat was dropped
module sensor_demux_buf
    import sensor_demux_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_CH      = DEF_N_CH,
    parameter int ADDR_W    = 3,
    parameter int HOLD_DATA = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   scan_en,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]      cur_ch,
    output logic                   err_addr
);

    generate
        if (ADDR_W != clog2(N_CH)) begin : g_bad_addr_w
            $error("sensor_demux_buf: ADDR_W must equal ceil(log2(N_CH))");
        end
        if ((N_CH < 2) || (N_CH > 64)) begin : g_bad_n_ch
            $error("sensor_demux_buf: N_CH must be within 2..64");
        end
    endgenerate

    localparam logic [ADDR_W:0]   LP_N_CH    = (ADDR_W + 1)'(N_CH);
    localparam logic [ADDR_W-1:0] LP_PTR_MAX = ADDR_W'(N_CH - 1);

    demux_mode_e       w_mode;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_range_ok;
    logic              w_tgt_free;
    logic              w_accept;
    logic [N_CH-1:0]   w_load;
    logic [N_CH-1:0]   w_free;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_err;

    assign w_mode = demux_mode_e'(scan_en);

    // Target selection and range check.
    always_comb begin
        case (w_mode)
            MODE_SCAN:   w_tgt = r_ptr;
            MODE_DIRECT: w_tgt = address;
            default:     w_tgt = address;
        endcase
        w_range_ok = ({1'b0, w_tgt} < LP_N_CH);
    end

    // Free flag of the targeted slot, looked up without indexing past N_CH.
    always_comb begin
        w_tgt_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_tgt == ADDR_W'(k)) begin
                w_tgt_free = w_free[k];
            end else begin
                w_tgt_free = w_tgt_free;
            end
        end
    end

    // Handshake: out-of-range beats are always taken so upstream cannot deadlock.
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (w_range_ok) begin
            in_ready = w_tgt_free;
        end else begin
            in_ready = 1'b1;
        end
        w_accept = in_valid & in_ready;
    end

    // One-hot load strobe toward the targeted slot.
    always_comb begin
        w_load = {N_CH{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            if (w_accept && w_range_ok && (w_tgt == ADDR_W'(k))) begin
                w_load[k] = 1'b1;
            end else begin
                w_load[k] = 1'b0;
            end
        end
    end

    // Scan pointer: moves only on beats accepted in scan mode, wraps at N_CH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= {ADDR_W{1'b0}};
        end else if (w_accept && scan_en) begin
            if (r_ptr == LP_PTR_MAX) begin
                r_ptr <= {ADDR_W{1'b0}};
            end else begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Dropped-beat pulse, high for the single cycle after the drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_range_ok;
        end
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_slot
            demux_chan_slot #(
                .DATA_W    (DATA_W),
                .HOLD_DATA (HOLD_DATA)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[k]),
                .i_data  (data_in),
                .i_ready (out_ready[k]),
                .o_valid (out_valid[k]),
                .o_data  (out_data[k*DATA_W +: DATA_W]),
                .o_free  (w_free[k])
            );
        end
    endgenerate

    assign cur_ch   = w_tgt;
    assign err_addr = r_err;

endmodule

// File: tb/tb_sensor_demux_buf.sv
// Bench for sensor_demux_buf: an 8-channel HOLD_DATA=1 instance and a
// 6-channel HOLD_DATA=0 instance share all inputs and are each compared with a
// behavioural model (arrays of valid/data per channel plus a pointer).
module tb_sensor_demux_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [2:0]  address = 3'd0;
    logic        scan_en = 1'b0;
    logic [7:0]  rdy8 = 8'hFF;
    logic [5:0]  rdy6;

    logic        inr8, inr6, err8, err6;
    logic [7:0]  ov8;
    logic [5:0]  ov6;
    logic [63:0] od8;
    logic [47:0] od6;
    logic [2:0]  cc8, cc6;

    int n_vec = 0;
    int n_err = 0;

    // model state: index 0 = 8-channel hold instance, 1 = 6-channel clear instance
    bit         m_v[2][8];
    logic [7:0] m_d[2][8];
    int         m_ptr[2];
    bit         m_err[2];

    assign rdy6 = rdy8[5:0];

    always #5 clk = ~clk;

    sensor_demux_buf #(.DATA_W(8), .N_CH(8), .ADDR_W(3), .HOLD_DATA(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr8),
        .data_in(data_in), .address(address), .scan_en(scan_en),
        .out_valid(ov8), .out_ready(rdy8), .out_data(od8),
        .cur_ch(cc8), .err_addr(err8));

    sensor_demux_buf #(.DATA_W(8), .N_CH(6), .ADDR_W(3), .HOLD_DATA(0)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr6),
        .data_in(data_in), .address(address), .scan_en(scan_en),
        .out_valid(ov6), .out_ready(rdy6), .out_data(od6),
        .cur_ch(cc6), .err_addr(err6));

    function automatic int m_n(input int i);
        return (i == 0) ? 8 : 6;
    endfunction

    function automatic int m_tgt(input int i);
        return scan_en ? m_ptr[i] : int'(address);
    endfunction

    function automatic bit m_inready(input int i);
        int t;
        t = m_tgt(i);
        if (rst) return 1'b0;
        if (t >= m_n(i)) return 1'b1;
        return !m_v[i][t] || rdy8[t];
    endfunction

    function automatic logic [7:0] m_vvec(input int i);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < m_n(i); k++) v[k] = m_v[i][k];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                m_v[i][k] = 1'b0;
                m_d[i][k] = 8'h00;
            end
            m_ptr[i] = 0;
            m_err[i] = 1'b0;
        end
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        int  t[2];
        bit  acc[2];
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            t[i]   = m_tgt(i);
            acc[i] = in_valid && m_inready(i);
        end
        for (int i = 0; i < 2; i++) begin
            m_err[i] = acc[i] && (t[i] >= m_n(i));
            for (int k = 0; k < m_n(i); k++) begin
                if (acc[i] && t[i] == k) begin
                    m_v[i][k] = 1'b1;
                    m_d[i][k] = data_in;
                end else if (m_v[i][k] && rdy8[k]) begin
                    m_v[i][k] = 1'b0;
                    if (i == 1) m_d[i][k] = 8'h00;
                end
            end
            if (acc[i] && scan_en) m_ptr[i] = (m_ptr[i] + 1) % m_n(i);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        model_reset();
        #1;
        n_vec++; if (inr8 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", inr8); end
        n_vec++; if (ov8 !== 8'h00 || ov6 !== 6'h00) begin n_err++; $display("FAIL reset_valid got %h/%h want 0", ov8, ov6); end
        n_vec++; if (od8 !== 64'h0 || od6 !== 48'h0) begin n_err++; $display("FAIL reset_data got %h/%h want 0", od8, od6); end
        n_vec++; if (err8 !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err8); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
    endtask

    task automatic test_direct();
        scan_en = 1'b0; rdy8 = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; address = 3'(k); data_in = 8'h10 + 8'(k);
            #1;
            n_vec++; if (inr8 !== 1'b1) begin n_err++; $display("FAIL direct_in_ready ch%0d got %b want 1", k, inr8); end
            tick();
            n_vec++; if (ov8 !== (8'h01 << k)) begin n_err++; $display("FAIL direct_valid ch%0d got %h want %h", k, ov8, 8'h01 << k); end
            n_vec++; if (od8[k*8 +: 8] !== 8'h10 + 8'(k)) begin n_err++; $display("FAIL direct_data ch%0d got %h want %h", k, od8[k*8 +: 8], 8'h10 + 8'(k)); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        scan_en = 1'b0; rdy8 = 8'hF7; address = 3'd3;
        in_valid = 1'b1; data_in = 8'hA5;
        #1;
        n_vec++; if (inr8 !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got %b want 1", inr8); end
        tick();
        data_in = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (inr8 !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b want 0", inr8); end
            tick();
            n_vec++; if (ov8[3] !== 1'b1 || od8[31:24] !== 8'hA5) begin n_err++; $display("FAIL bp_held got v=%b d=%h want v=1 d=a5", ov8[3], od8[31:24]); end
        end
        rdy8 = 8'hFF;
        #1;
        n_vec++; if (inr8 !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", inr8); end
        tick();
        n_vec++; if (ov8[3] !== 1'b1 || od8[31:24] !== 8'h5A) begin n_err++; $display("FAIL bp_swap got v=%b d=%h want v=1 d=5a", ov8[3], od8[31:24]); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (ov8[3] !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", ov8[3]); end
    endtask

    task automatic test_scan();
        scan_en = 1'b1; rdy8 = 8'hFF; in_valid = 1'b1;
        for (int b = 0; b < 10; b++) begin
            data_in = 8'(b + 1);
            #1;
            n_vec++; if (cc8 !== 3'(b % 8)) begin n_err++; $display("FAIL scan_ptr beat%0d got %0d want %0d", b, cc8, b % 8); end
            tick();
            n_vec++; if (ov8[b % 8] !== 1'b1 || od8[(b % 8)*8 +: 8] !== 8'(b + 1)) begin n_err++; $display("FAIL scan_data beat%0d got v=%b d=%h want %h", b, ov8[b % 8], od8[(b % 8)*8 +: 8], 8'(b + 1)); end
        end
        in_valid = 1'b0;
        #1;
        n_vec++; if (cc8 !== 3'd2) begin n_err++; $display("FAIL scan_end_ptr got %0d want 2", cc8); end
        // occupy ch2 in direct mode, then stall the scan pointer on it
        scan_en = 1'b0; address = 3'd2; rdy8 = 8'h00; in_valid = 1'b1; data_in = 8'hEE;
        tick();
        scan_en = 1'b1; data_in = 8'h0B;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (inr8 !== 1'b0 || cc8 !== 3'd2) begin n_err++; $display("FAIL scan_stall got rdy=%b ptr=%0d want 0/2", inr8, cc8); end
            tick();
        end
        rdy8 = 8'hFF;
        tick();
        in_valid = 1'b0;
        #1;
        n_vec++; if (od8[23:16] !== 8'h0B || cc8 !== 3'd3) begin n_err++; $display("FAIL scan_resume got d=%h ptr=%0d want 0b/3", od8[23:16], cc8); end
    endtask

    task automatic test_out_of_range();
        logic [5:0] snap;
        scan_en = 1'b0; rdy8 = 8'h00;
        for (int a = 6; a < 8; a++) begin
            address = 3'(a); data_in = 8'hFF; in_valid = 1'b1;
            snap = ov6;
            #1;
            n_vec++; if (inr6 !== 1'b1) begin n_err++; $display("FAIL oor_ready addr%0d got %b want 1", a, inr6); end
            tick();
            in_valid = 1'b0;
            n_vec++; if (err6 !== 1'b1) begin n_err++; $display("FAIL oor_err addr%0d got %b want 1", a, err6); end
            n_vec++; if (ov6 !== snap) begin n_err++; $display("FAIL oor_valid addr%0d got %h want %h", a, ov6, snap); end
            tick();
            n_vec++; if (err6 !== 1'b0) begin n_err++; $display("FAIL oor_err_clear addr%0d got %b want 0", a, err6); end
        end
        rdy8 = 8'hFF;
        tick();
    endtask

    task automatic test_hold_data();
        scan_en = 1'b0; address = 3'd2; data_in = 8'h3C; in_valid = 1'b1; rdy8 = 8'hFB;
        tick();
        in_valid = 1'b0;
        n_vec++; if (od8[23:16] !== 8'h3C || od6[23:16] !== 8'h3C) begin n_err++; $display("FAIL hold_loaded got %h/%h want 3c", od8[23:16], od6[23:16]); end
        rdy8 = 8'hFF;
        tick();
        n_vec++; if (ov8[2] !== 1'b0 || ov6[2] !== 1'b0) begin n_err++; $display("FAIL hold_valid got %b/%b want 0", ov8[2], ov6[2]); end
        n_vec++; if (od8[23:16] !== 8'h3C) begin n_err++; $display("FAIL hold_keep got %h want 3c", od8[23:16]); end
        n_vec++; if (od6[23:16] !== 8'h00) begin n_err++; $display("FAIL hold_clear got %h want 00", od6[23:16]); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; model_reset(); #1; @(posedge clk); #1; rst = 1'b0; #1;
        scan_en = 1'b1; rdy8 = 8'hE3; in_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            data_in = 8'h40 + 8'(b);
            tick();
        end
        n_vec++; if (ov8 !== 8'h1C || cc8 !== 3'd5) begin n_err++; $display("FAIL mrst_setup got v=%h ptr=%0d want 1c/5", ov8, cc8); end
        #2; rst = 1'b1; model_reset(); #1;
        n_vec++; if (ov8 !== 8'h00 || od8 !== 64'h0 || ov6 !== 6'h00) begin n_err++; $display("FAIL mrst_clear got v=%h d=%h", ov8, od8); end
        n_vec++; if (inr8 !== 1'b0 || inr6 !== 1'b0 || cc8 !== 3'd0) begin n_err++; $display("FAIL mrst_ready got rdy=%b ptr=%0d want 0/0", inr8, cc8); end
        @(posedge clk); #1; rst = 1'b0;
        rdy8 = 8'hFF; data_in = 8'h99;
        tick();
        in_valid = 1'b0;
        n_vec++; if (ov8 !== 8'h01 || od8[7:0] !== 8'h99) begin n_err++; $display("FAIL mrst_first got v=%h d=%h want 01/99", ov8, od8[7:0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            address  = 3'($urandom_range(0, 7));
            scan_en  = 1'($urandom_range(0, 1));
            rdy8     = 8'($urandom);
            #1;
            n_vec++; if (inr8 !== m_inready(0) || inr6 !== m_inready(1)) begin n_err++; $display("FAIL rnd_ready cyc%0d got %b/%b want %b/%b", c, inr8, inr6, m_inready(0), m_inready(1)); end
            n_vec++; if (int'(cc8) !== m_tgt(0) || int'(cc6) !== m_tgt(1)) begin n_err++; $display("FAIL rnd_cur_ch cyc%0d got %0d/%0d want %0d/%0d", c, cc8, cc6, m_tgt(0), m_tgt(1)); end
            tick();
            n_vec++; if (ov8 !== m_vvec(0) || {2'b00, ov6} !== m_vvec(1)) begin n_err++; $display("FAIL rnd_valid cyc%0d got %h/%h want %h/%h", c, ov8, ov6, m_vvec(0), m_vvec(1)); end
            n_vec++; if (err8 !== m_err[0] || err6 !== m_err[1]) begin n_err++; $display("FAIL rnd_err cyc%0d got %b/%b want %b/%b", c, err8, err6, m_err[0], m_err[1]); end
            for (int k = 0; k < 8; k++) begin
                n_vec++; if (od8[k*8 +: 8] !== m_d[0][k]) begin n_err++; $display("FAIL rnd_data8 cyc%0d ch%0d got %h want %h", c, k, od8[k*8 +: 8], m_d[0][k]); end
            end
            for (int k = 0; k < 6; k++) begin
                n_vec++; if (od6[k*8 +: 8] !== m_d[1][k]) begin n_err++; $display("FAIL rnd_data6 cyc%0d ch%0d got %h want %h", c, k, od6[k*8 +: 8], m_d[1][k]); end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_backpressure();
        test_scan();
        test_out_of_range();
        test_hold_data();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
